// File: rtl/tero_averager.sv
// TERO loop response averager: accumulates oscillation counts per evaluation,
// divides by the evaluation count on store, and holds one average per loop.
module tero_averager #(
  parameter int NUM_LOOPS        = 4,
  parameter int COUNT_BITS       = 16,
  parameter int REPETITIONS_BITS = 16,
  parameter int SEL_BITS         = $clog2(NUM_LOOPS-1)+1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_puf,
  input  logic                  enable_puf,
  input  logic                  store_response_puf,
  input  logic [SEL_BITS-1:0]   select_puf,
  input  logic [COUNT_BITS-1:0] tero_count,
  input  logic                  clear_all,
  input  logic [SEL_BITS-1:0]   rd_sel,
  output logic [COUNT_BITS-1:0] rd_data,
  output logic                  next_enable,
  output logic [NUM_LOOPS-1:0]  resp_valid,
  output logic                  all_valid,
  output logic                  err_sat,
  output logic                  err_empty,
  output logic                  err_overrun,
  output logic                  err_range
);

  localparam int ACC_BITS = COUNT_BITS + REPETITIONS_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;

  logic                  enable_q;
  logic                  eval_end;
  logic [ACC_BITS-1:0]   acc;
  logic [ACC_BITS:0]     sum;
  logic [ACC_BITS-1:0]   acc_sum;
  logic                  sum_ovf;
  logic [REPETITIONS_BITS-1:0] sample_cnt;
  logic [SEL_BITS-1:0]   sel_q;
  logic                  sel_in_range;
  logic [COUNT_BITS-1:0] avg;
  logic [COUNT_BITS-1:0] mem [NUM_LOOPS];
  logic [COUNT_BITS-1:0] rd_next;

  logic accept_sample;
  logic clear_acc;
  logic start_divide;
  logic do_write;
  logic clear_flags;
  logic flag_overrun;
  logic flag_empty;

  // One-cycle pulse on the first edge that sees enable_puf low after high.
  assign eval_end = enable_q & ~enable_puf;

  assign sum          = {1'b0, acc} + {{(REPETITIONS_BITS+1){1'b0}}, tero_count};
  assign sum_ovf      = sum[ACC_BITS];
  assign acc_sum      = sum_ovf ? '1 : sum[ACC_BITS-1:0];
  assign sel_in_range = int'(sel_q) < NUM_LOOPS;

  assign next_enable  = (state == IDLE) || (state == ACCUM);
  assign all_valid    = &resp_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block is given a default first, otherwise a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_next    = state;
    accept_sample = 1'b0;
    clear_acc     = 1'b0;
    start_divide  = 1'b0;
    do_write      = 1'b0;
    clear_flags   = 1'b0;
    flag_overrun  = 1'b0;
    flag_empty    = 1'b0;
    unique case (state)
      IDLE, ACCUM: begin
        clear_flags = clear_all;
        if (reset_puf) begin
          clear_acc  = 1'b1;
          state_next = IDLE;
        end else begin
          accept_sample = eval_end;
          if (store_response_puf) begin
            start_divide = 1'b1;
            flag_empty   = (state == IDLE) && (sample_cnt == '0) && !eval_end;
            state_next   = DIVIDE;
          end else if (eval_end) begin
            state_next = ACCUM;
          end
        end
      end
      DIVIDE: begin
        flag_overrun = store_response_puf | eval_end;
        state_next   = WRITE;
      end
      WRITE: begin
        flag_overrun = store_response_puf | eval_end;
        do_write     = 1'b1;
        clear_acc    = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, sample counter and division pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q   <= 1'b0;
      acc        <= '0;
      sample_cnt <= '0;
      sel_q      <= '0;
      avg        <= '0;
    end else begin
      enable_q <= enable_puf;
      if (clear_acc) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else if (accept_sample) begin
        acc        <= acc_sum;
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (start_divide) sel_q <= select_puf;
      if (state == DIVIDE) avg <= COUNT_BITS'(acc >> (REPETITIONS_BITS-1));
    end
  end

  // NOTE: the response store sits inside the async reset because the reset
  // state must read back as all zeros; this keeps it a flop array, not a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) mem[i] <= '0;
      resp_valid <= '0;
    end else begin
      if (clear_flags) resp_valid <= '0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (do_write && sel_q == SEL_BITS'(i)) begin
          mem[i]        <= avg;
          resp_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Sticky error flags; a flag raised in the same cycle as clear_all survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sat     <= 1'b0;
      err_empty   <= 1'b0;
      err_overrun <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (clear_flags) begin
        err_sat     <= 1'b0;
        err_empty   <= 1'b0;
        err_overrun <= 1'b0;
        err_range   <= 1'b0;
      end
      if (accept_sample && sum_ovf) err_sat     <= 1'b1;
      if (flag_empty)               err_empty   <= 1'b1;
      if (flag_overrun)             err_overrun <= 1'b1;
      if (do_write && !sel_in_range) err_range  <= 1'b1;
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (rd_sel == SEL_BITS'(i)) rd_next = mem[i];
    end
  end

  // Registered read port: a same-edge write is seen on the following read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= rd_next;
  end

endmodule

// File: doc/tero_averager.md
TERO_AVERAGER -- requirements
Module: tero_averager

Interface
REQ-001 Parameter NUM_LOOPS, default 4, number of TERO loops whose averages are held.
REQ-002 Parameter COUNT_BITS, default 16, width of one TERO oscillation count and of one stored average.
REQ-003 Parameter REPETITIONS_BITS, default 16; divisor is 2**(REPETITIONS_BITS-1) evaluations per loop.
REQ-004 Parameter SEL_BITS, default $clog2(NUM_LOOPS-1)+1, width of loop select and read address.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 reset_puf  in  1  loop re-init pulse from the sequencer; clears the accumulation in progress.
REQ-008 enable_puf  in  1  high while the selected loop evaluates; the high-to-low edge marks one finished evaluation.
REQ-009 store_response_puf  in  1  request to commit the average for loop select_puf.
REQ-010 select_puf  in  SEL_BITS  index of the loop under evaluation.
REQ-011 tero_count  in  COUNT_BITS  oscillation count of the selected loop, stable while enable_puf falls.
REQ-012 clear_all  in  1  synchronous clear of all valid bits and error flags.
REQ-013 rd_sel / rd_data  in SEL_BITS / out COUNT_BITS  read address and registered read data.
REQ-014 next_enable  out  1  high when the block can accept a new evaluation or store.
REQ-015 resp_valid  out  NUM_LOOPS  bit i set once the average for loop i has been written.
REQ-016 all_valid  out  1  AND of all resp_valid bits.
REQ-017 err_sat / err_empty / err_overrun / err_range  out  1 each  sticky error flags.

Function
REQ-018 Accumulator width: COUNT_BITS+REPETITIONS_BITS, unsigned; sample counter width: REPETITIONS_BITS.
REQ-019 eval_end: enable_puf registered 1 when the live enable_puf is 0 (one cycle, delayed one clk after the falling edge).
REQ-020 On eval_end: acc += zero-extended tero_count and sample_cnt += 1 (the counter wraps).
REQ-021 Sum overflowing the accumulator: acc saturates at all-ones and err_sat is set.
REQ-022 FSM states: IDLE, ACCUM, DIVIDE, WRITE.
REQ-023 IDLE -> ACCUM on eval_end; ACCUM holds on further eval_end; IDLE/ACCUM -> DIVIDE on store_response_puf.
REQ-024 DIVIDE (1 cycle): avg = acc >> (REPETITIONS_BITS-1); the result is truncated to COUNT_BITS bits.
REQ-025 WRITE (1 cycle): mem[select_puf] = avg, resp_valid[select_puf] = 1, acc = 0, sample_cnt = 0; next state IDLE.
REQ-026 next_enable = 1 in IDLE/ACCUM and 0 in DIVIDE/WRITE, so store-to-ready latency is 2 cycles.
REQ-027 select_puf is captured on entry to DIVIDE; changes after that have no effect.
REQ-028 Captured select_puf >= NUM_LOOPS: no write, no valid-bit change, err_range set, acc still cleared.
REQ-029 Store in IDLE with sample_cnt = 0: writes 0 and sets err_empty.
REQ-030 eval_end and store in the same cycle: the sample is added to acc before division.
REQ-031 Store or eval_end during DIVIDE/WRITE: ignored and err_overrun set.
REQ-032 reset_puf in IDLE/ACCUM: acc = 0, sample_cnt = 0, go to IDLE; mem and valid bits are kept.
REQ-033 reset_puf wins over eval_end in the same cycle; in DIVIDE/WRITE, reset_puf is ignored.
REQ-034 rd_data = mem[rd_sel] registered, 1-cycle latency; out-of-range rd_sel returns 0.
REQ-035 A read of the entry written in the same cycle returns the old value; the new value appears on the next read.
REQ-036 clear_all clears resp_valid and all err_* flags; it does not clear mem or acc; ignored in DIVIDE/WRITE.

Reset
REQ-037 reset low, asynchronous: state IDLE, acc 0, sample_cnt 0, mem all 0, resp_valid 0, all_valid 0, errors 0, rd_data 0, next_enable 1.
REQ-038 reset deassertion takes effect on the first clk edge after release; the bench does not treat a reset pulse shorter than one clk as reliable.

Verification (NUM_LOOPS=4, COUNT_BITS=8, REPETITIONS_BITS=3, divisor 4)
REQ-039 Counts 10,12,14,16 with select_puf=2, then store -> mem[2]=13, resp_valid=0100, next_enable low for exactly 2 cycles.
REQ-040 Four loops, each given 4 counts of 8*i, then a store per loop -> mem={0,8,16,24}, all_valid=1.
REQ-041 Counts 200,200,200 then reset_puf, then 4x 40 and store on loop 1 -> mem[1]=40.
REQ-042 Store immediately after reset with no evaluations -> mem[sel]=0, err_empty=1; second store during DIVIDE -> err_overrun=1.
REQ-043 Store with select_puf=5 (SEL_BITS=3) -> no write, err_range=1; clear_all -> all flags and valid bits 0.
REQ-044 reset driven low during WRITE -> asynchronous return to the reset values, with mem all 0.
